// File: rtl/mod_counter_sequencer.sv
// Sequences a loadable modulo-MOD up counter through a commanded run of num_wraps wrap-arounds.
// Registered outputs only; start is validated in IDLE and rejected commands pulse cmd_err.
module mod_counter_sequencer #(
   parameter int MOD = 12,
   parameter int CW  = 4,
   parameter int WW  = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          start,
   input  logic [CW-1:0] start_val,
   input  logic [WW-1:0] num_wraps,
   input  logic          pause,
   input  logic          abort,
   output logic          busy,
   output logic          done,
   output logic          cmd_err,
   output logic [CW-1:0] count,
   output logic [WW-1:0] wraps_left
);

   localparam int            MAX_I   = MOD - 1;
   localparam logic [CW:0]   MOD_EXT = MOD[CW:0];
   localparam logic [CW-1:0] MAX_CNT = MAX_I[CW-1:0];

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic [WW-1:0] wraps_q, wraps_d;
   logic [CW-1:0] sv_q, sv_d;
   logic [WW-1:0] nw_q, nw_d;
   logic          cmd_err_q, cmd_err_d;
   logic          cmd_bad;
   logic          last_wrap;

   assign cmd_bad   = ({1'b0, start_val} >= MOD_EXT) || (num_wraps == '0);
   assign last_wrap = (count_q == MAX_CNT) && (wraps_q == WW'(1));

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: abort beats pause beats counting in RUN
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start && !cmd_bad) state_d = S_LOAD;
         S_LOAD: state_d = abort ? S_IDLE : S_RUN;
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (!pause && last_wrap) begin
               state_d = S_DONE;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values
   always_comb begin
      count_d   = count_q;
      wraps_d   = wraps_q;
      sv_d      = sv_q;
      nw_d      = nw_q;
      cmd_err_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cmd_bad) begin
                  cmd_err_d = 1'b1;
               end else begin
                  sv_d = start_val;
                  nw_d = num_wraps;
               end
            end
         end
         S_LOAD: begin
            if (abort) begin
               count_d = '0;
               wraps_d = '0;
            end else begin
               count_d = sv_q;
               wraps_d = nw_q;
            end
         end
         S_RUN: begin
            if (abort) begin
               count_d = '0;
               wraps_d = '0;
            end else if (!pause) begin
               if (count_q == MAX_CNT) begin
                  count_d = '0;
                  // Guarded so wraps_left can never underflow
                  if (wraps_q != '0) wraps_d = wraps_q - WW'(1);
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         S_DONE: begin
            count_d = '0;
            wraps_d = '0;
         end
         default: begin
            count_d = '0;
            wraps_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q   <= '0;
         wraps_q   <= '0;
         sv_q      <= '0;
         nw_q      <= '0;
         cmd_err_q <= 1'b0;
      end else begin
         count_q   <= count_d;
         wraps_q   <= wraps_d;
         sv_q      <= sv_d;
         nw_q      <= nw_d;
         cmd_err_q <= cmd_err_d;
      end
   end

   // Output decode
   always_comb begin
      busy       = (state_q == S_LOAD) || (state_q == S_RUN);
      done       = (state_q == S_DONE);
      cmd_err    = cmd_err_q;
      count      = count_q;
      wraps_left = wraps_q;
   end

endmodule

// File: tb/tb_mod_counter_sequencer.sv
// Directed bench for mod_counter_sequencer (MOD=12): reset, nominal run, rejects, pause, abort, ignored starts.
module tb_mod_counter_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] start_val;
   logic [3:0] num_wraps;
   logic       pause;
   logic       abort;
   logic       busy;
   logic       done;
   logic       cmd_err;
   logic [3:0] count;
   logic [3:0] wraps_left;

   int total = 0;
   int bad   = 0;

   mod_counter_sequencer #(.MOD(12), .CW(4), .WW(4)) dut (
      .clock      (clk),
      .reset      (rst),
      .start      (start),
      .start_val  (start_val),
      .num_wraps  (num_wraps),
      .pause      (pause),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .cmd_err    (cmd_err),
      .count      (count),
      .wraps_left (wraps_left)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues a start, leaving the DUT in LOAD on return
   task automatic kick(input logic [3:0] sv, input logic [3:0] nw);
      start_val = sv;
      num_wraps = nw;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 0; start_val = 0; num_wraps = 0; pause = 0; abort = 0;
      tick(); tick();
      total++;
      if ({busy, done, cmd_err, count, wraps_left} !== 11'd0) begin
         bad++; $display("FAIL reset_state: got busy=%b done=%b err=%b cnt=%0d wl=%0d, want all 0", busy, done, cmd_err, count, wraps_left);
      end
      rst = 1'b0;
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
      end
   endtask

   task automatic test_nominal();
      logic [3:0] exp_c;
      logic [3:0] exp_w;
      int busy_cycles = 0;
      kick(4'd10, 4'd2);
      if (busy === 1'b1) busy_cycles++;
      for (int i = 0; i < 14; i++) begin
         tick();
         exp_c = 4'((10 + i) % 12);
         exp_w = (i < 2) ? 4'd2 : 4'd1;
         if (busy === 1'b1) busy_cycles++;
         total++;
         if (count !== exp_c || wraps_left !== exp_w || busy !== 1'b1) begin
            bad++; $display("FAIL nominal_run[%0d]: got cnt=%0d wl=%0d busy=%b, want cnt=%0d wl=%0d busy=1", i, count, wraps_left, busy, exp_c, exp_w);
         end
      end
      tick();
      total++;
      if (done !== 1'b1 || busy !== 1'b0 || count !== 4'd0 || wraps_left !== 4'd0) begin
         bad++; $display("FAIL nominal_done: got done=%b busy=%b cnt=%0d wl=%0d, want 1 0 0 0", done, busy, count, wraps_left);
      end
      total++;
      if (busy_cycles != 15) begin
         bad++; $display("FAIL nominal_busy_len: got %0d cycles, want 15", busy_cycles);
      end
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL nominal_idle: got done=%b busy=%b, want 0 0", done, busy);
      end
   endtask

   task automatic test_reject();
      logic [3:0] svs [3] = '{4'd12, 4'd13, 4'd3};
      logic [3:0] nws [3] = '{4'd1, 4'd1, 4'd0};
      for (int i = 0; i < 3; i++) begin
         kick(svs[i], nws[i]);
         total++;
         if (cmd_err !== 1'b1 || busy !== 1'b0 || count !== 4'd0 || wraps_left !== 4'd0) begin
            bad++; $display("FAIL reject_pulse[%0d]: got err=%b busy=%b cnt=%0d wl=%0d, want 1 0 0 0", i, cmd_err, busy, count, wraps_left);
         end
         tick();
         total++;
         if (cmd_err !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL reject_clear[%0d]: got err=%b busy=%b, want 0 0", i, cmd_err, busy);
         end
      end
   endtask

   task automatic test_boundary();
      kick(4'd11, 4'd1);
      total++;
      if (busy !== 1'b1 || cmd_err !== 1'b0) begin
         bad++; $display("FAIL boundary_accept: got busy=%b err=%b, want 1 0", busy, cmd_err);
      end
      tick();
      total++;
      if (count !== 4'd11 || wraps_left !== 4'd1) begin
         bad++; $display("FAIL boundary_run: got cnt=%0d wl=%0d, want 11 1", count, wraps_left);
      end
      tick();
      total++;
      if (done !== 1'b1 || count !== 4'd0) begin
         bad++; $display("FAIL boundary_done: got done=%b cnt=%0d, want 1 0", done, count);
      end
      tick();
   endtask

   task automatic test_pause();
      logic [3:0] exp_c [16] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4,
                                 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd11};
      logic [15:0] pmask = 16'b0100_0000_0111_0000;
      kick(4'd0, 4'd1);
      tick();
      for (int i = 0; i < 16; i++) begin
         total++;
         if (count !== exp_c[i] || busy !== 1'b1 || wraps_left !== 4'd1) begin
            bad++; $display("FAIL pause_seq[%0d]: got cnt=%0d busy=%b wl=%0d, want cnt=%0d busy=1 wl=1", i, count, busy, wraps_left, exp_c[i]);
         end
         pause = pmask[i];
         tick();
      end
      pause = 1'b0;
      total++;
      if (done !== 1'b1 || count !== 4'd0 || wraps_left !== 4'd0) begin
         bad++; $display("FAIL pause_done: got done=%b cnt=%0d wl=%0d, want 1 0 0", done, count, wraps_left);
      end
      tick();
   endtask

   task automatic test_abort();
      // abort together with pause in RUN
      kick(4'd0, 4'd2);
      tick();
      for (int i = 0; i < 7; i++) tick();
      total++;
      if (count !== 4'd7) begin
         bad++; $display("FAIL abort_setup: got cnt=%0d, want 7", count);
      end
      abort = 1'b1; pause = 1'b1;
      tick();
      abort = 1'b0; pause = 1'b0;
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || count !== 4'd0 || wraps_left !== 4'd0) begin
         bad++; $display("FAIL abort_run: got busy=%b done=%b cnt=%0d wl=%0d, want 0 0 0 0", busy, done, count, wraps_left);
      end
      tick();
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL abort_no_done: got done=%b busy=%b, want 0 0", done, busy);
      end
      // abort in LOAD
      kick(4'd5, 4'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      total++;
      if (busy !== 1'b0 || count !== 4'd0 || wraps_left !== 4'd0) begin
         bad++; $display("FAIL abort_load: got busy=%b cnt=%0d wl=%0d, want 0 0 0", busy, count, wraps_left);
      end
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || count !== 4'd0) begin
         bad++; $display("FAIL abort_load_idle: got busy=%b done=%b cnt=%0d, want 0 0 0", busy, done, count);
      end
      // abort in IDLE has no effect, even alongside a start
      abort = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0 || cmd_err !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL abort_idle: got busy=%b err=%b done=%b, want 0 0 0", busy, cmd_err, done);
      end
      kick(4'd9, 4'd1);
      abort = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL abort_idle_start: got busy=%b, want 1", busy);
      end
      tick(); tick(); tick();
      total++;
      if (count !== 4'd11) begin
         bad++; $display("FAIL abort_idle_run: got cnt=%0d, want 11", count);
      end
      tick();
      total++;
      if (done !== 1'b1) begin
         bad++; $display("FAIL abort_idle_done: got done=%b, want 1", done);
      end
      tick();
   endtask

   task automatic test_start_ignored();
      kick(4'd8, 4'd1);
      tick();
      start_val = 4'd2; num_wraps = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      total++;
      if (count !== 4'd9 || wraps_left !== 4'd1 || busy !== 1'b1 || cmd_err !== 1'b0) begin
         bad++; $display("FAIL ignore_run: got cnt=%0d wl=%0d busy=%b err=%b, want 9 1 1 0", count, wraps_left, busy, cmd_err);
      end
      tick(); tick();
      total++;
      if (count !== 4'd11 || wraps_left !== 4'd1) begin
         bad++; $display("FAIL ignore_orig: got cnt=%0d wl=%0d, want 11 1", count, wraps_left);
      end
      tick();
      total++;
      if (done !== 1'b1) begin
         bad++; $display("FAIL ignore_done: got done=%b, want 1", done);
      end
      // start held through DONE and into the following IDLE cycle
      start_val = 4'd11; num_wraps = 4'd1; start = 1'b1;
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || cmd_err !== 1'b0) begin
         bad++; $display("FAIL ignore_in_done: got busy=%b done=%b err=%b, want 0 0 0", busy, done, cmd_err);
      end
      tick();
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++; $display("FAIL accept_after_done: got busy=%b, want 1", busy);
      end
      tick();
      total++;
      if (count !== 4'd11 || wraps_left !== 4'd1) begin
         bad++; $display("FAIL accept_after_done_run: got cnt=%0d wl=%0d, want 11 1", count, wraps_left);
      end
      tick();
      tick();
   endtask

   task automatic test_reset_midrun();
      kick(4'd0, 4'd1);
      tick();
      for (int i = 0; i < 5; i++) tick();
      total++;
      if (count !== 4'd5 || busy !== 1'b1) begin
         bad++; $display("FAIL midrun_setup: got cnt=%0d busy=%b, want 5 1", count, busy);
      end
      #2 rst = 1'b1;
      #1;
      total++;
      if ({busy, done, cmd_err, count, wraps_left} !== 11'd0) begin
         bad++; $display("FAIL midrun_reset: got busy=%b done=%b err=%b cnt=%0d wl=%0d, want all 0", busy, done, cmd_err, count, wraps_left);
      end
      tick();
      #2 rst = 1'b0;
      tick();
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || count !== 4'd0) begin
         bad++; $display("FAIL midrun_idle: got busy=%b done=%b cnt=%0d, want 0 0 0", busy, done, count);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_reject();
      test_boundary();
      test_pause();
      test_abort();
      test_start_ignored();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mod_counter_sequencer.md
Name: mod_counter_sequencer

Overview:
- Controller that sequences a loadable modulo-MOD up counter through a commanded run.
- Each run loads a start value, counts a programmed number of wrap-arounds, then signals completion.
- Sits between a command source (control FSM or host register) and the counter datapath.
- Owns the counter register, wrap bookkeeping, pause/abort control and command validation.

Parameters:
MOD, 12, counter modulus; count runs 0..MOD-1
CW, 4, count width; must satisfy 2^CW >= MOD
WW, 4, wrap-count width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
start  in  1  run request; sampled only in IDLE
start_val  in  CW  counter load value
num_wraps  in  WW  number of wraps before completion
pause  in  1  holds count while high, RUN only
abort  in  1  terminates run, LOAD/RUN only
busy  out  1  high in LOAD and RUN
done  out  1  one-cycle completion pulse
cmd_err  out  1  one-cycle pulse for a rejected start
count  out  CW  current counter value
wraps_left  out  WW  remaining wraps

Behaviour:
- States: IDLE, LOAD, RUN, DONE. All outputs registered or decoded from state; no combinational input-to-output paths.
- Output decode: busy = (state==LOAD or RUN); done = (state==DONE).
- Reset (async, any state, mid-run included):
  - state=IDLE
  - count=0, wraps_left=0
  - busy=0, done=0, cmd_err=0
- cmd_err: registered; defaults to 0 every cycle unless set by a rejected start.
- IDLE, start=1:
  - Reject if start_val >= MOD or num_wraps == 0: cmd_err=1 for the next cycle, stay IDLE, count and wraps_left unchanged.
  - Otherwise latch start_val and num_wraps, go to LOAD.
- IDLE, start=0: hold. abort and pause are ignored in IDLE.
- LOAD (1 cycle): count <= latched start_val, wraps_left <= latched num_wraps, go to RUN.
  - abort in LOAD: go to IDLE, count=0, wraps_left=0, no done.
- RUN, priority abort > pause > count:
  - abort: go to IDLE next edge, count=0, wraps_left=0, no done.
  - pause: count and wraps_left hold; state stays RUN.
  - count < MOD-1: count <= count+1.
  - count == MOD-1: count <= 0 and wraps_left <= wraps_left-1. If wraps_left was 1, go to DONE.
- DONE (1 cycle): count=0, wraps_left=0, busy=0. Go to IDLE unconditionally; a start in DONE is ignored.
- Start while busy is ignored with no cmd_err; latched values are unaffected.
- Latency:
  - start sampled at edge k.
  - busy=1 after edge k+1 (LOAD).
  - count=start_val after edge k+2 (first RUN cycle).
  - Total RUN edges = (MOD - start_val) + (num_wraps-1)*MOD, plus pause cycles.
- Arithmetic: count never exceeds MOD-1; wraps_left never underflows (decrement occurs only when it is >= 1).

Test Plan:
- Reset mid-run: reset=1 asserted asynchronously during RUN (count=5) -> count=0, wraps_left=0, busy=0, done=0 immediately, before the next edge; state IDLE.
- Nominal run: MOD=12, start_val=10, num_wraps=2.
  - Expect count 10,11,0,1,…,11,0.
  - wraps_left goes 2→1 at the first wrap, 1→0 at the second.
  - busy high 15 cycles (1 LOAD + 14 RUN).
  - done one-cycle pulse at edge k+16; IDLE after edge k+17.
- Rejected commands:
  - start_val=12 (num_wraps=1) -> cmd_err pulse, busy stays 0.
  - start_val=13 (num_wraps=1) -> cmd_err pulse, busy stays 0.
  - start_val=3, num_wraps=0 -> cmd_err pulse, busy stays 0.
  - Boundary start_val=11, num_wraps=1 -> accepted, 1 RUN edge, then done.
- Pause:
  - Setup: start_val=0, num_wraps=1.
  - Stimulus: pause high 3 cycles at count=4, including a pause during the count==11 cycle.
  - Required: count holds 4 for 3 cycles; the wrap is delayed by the pause; done arrives 3 cycles later plus the delayed wrap cycles.
- Abort/priority:
  - abort+pause together at count=7 in RUN -> IDLE next edge, count=0, no done pulse.
  - abort in LOAD -> IDLE, no RUN cycle.
  - abort in IDLE -> no effect.
- Start ignored:
  - start pulses during RUN (new start_val=2) -> no effect; run completes with the original values.
  - start asserted in the DONE cycle -> ignored; a start on the following IDLE cycle is accepted.
